// File: rtl/instr_encoder.sv
// MIPS instruction encoder and instruction-memory loader: packs field-level requests
// into 32-bit words, buffers them in a FIFO and writes them from a programmable base.
// Define INSTR_ENC_CHECK_EN to drop illegal requests (kind 7) and flag them on err.
module instr_encoder #(
  parameter int AW         = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  input  logic          abort,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_kind,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_shamt,
  input  logic [5:0]    req_funct,
  input  logic [15:0]   req_imm,
  input  logic [25:0]   req_target,
  output logic          im_we,
  input  logic          im_ready,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wd,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] acc_q, acc_d;
  logic [LW-1:0] wr_q, wr_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [31:0]   enc_word;
  logic          fifo_full, fifo_empty;
  logic          accept, push, pop;

  always_comb begin
    enc_word = '0;
    case (req_kind)
      3'd0: enc_word = {6'h00, req_rs, req_rt, req_rd, req_shamt, req_funct};
      3'd1: enc_word = {6'h08, req_rs, req_rt, req_imm};
      3'd2: enc_word = {6'h04, req_rs, req_rt, req_imm};
      3'd3: enc_word = {6'h02, req_target};
      3'd4: enc_word = {6'h03, req_target};
      3'd5: enc_word = {6'h2B, req_rs, req_rt, req_imm};
      3'd6: enc_word = {6'h23, req_rs, req_rt, req_imm};
      default: enc_word = '0;
    endcase
  end

  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign req_ready  = (state_q == LOAD) && !fifo_full && (acc_q < len_q);
  assign im_we      = (state_q == LOAD) && !fifo_empty;
  assign im_addr    = addr_q;
  assign im_wd      = im_we ? mem_q[rd_ptr_q] : '0;
  assign busy       = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign accept     = req_valid && req_ready;
  assign pop        = im_we && im_ready;

`ifdef INSTR_ENC_CHECK_EN
  logic err_q, err_d;
  assign push = accept && (req_kind != 3'd7);
  assign err  = err_q;
`else
  assign push = accept;
  assign err  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    wr_d     = wr_q;
    len_d    = len_q;
    addr_d   = addr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
`ifdef INSTR_ENC_CHECK_EN
    err_d    = err_q;
    if (accept && (req_kind == 3'd7)) err_d = 1'b1;
`endif

    if (push) begin
      mem_d[wr_ptr_q] = enc_word;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      acc_d           = acc_q + LW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      addr_d   = addr_q + AW'(1);
      wr_d     = wr_q + LW'(1);
      if ((wr_q + LW'(1)) == len_q) state_d = DONE;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // A new session can only begin from IDLE or DONE; abort below overrides it.
    if (start && (state_q != LOAD)) begin
      acc_d    = '0;
      wr_d     = '0;
      len_d    = length;
      addr_d   = base_addr;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      state_d  = (length == '0) ? DONE : LOAD;
`ifdef INSTR_ENC_CHECK_EN
      err_d    = 1'b0;
`endif
    end

    if (abort) begin
      acc_d    = '0;
      wr_d     = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      wr_q     <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
`ifdef INSTR_ENC_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      wr_q     <= wr_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
`ifdef INSTR_ENC_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: randomized requests checked against a field-packing
// reference model and a queue of expected memory writes.
module tb_instr_encoder;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          abort = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_kind = '0;
  logic [4:0]    req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
  logic [5:0]    req_funct = '0;
  logic [15:0]   req_imm = '0;
  logic [25:0]   req_target = '0;
  logic          im_we;
  logic          im_ready = 1'b0;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wd;
  logic          busy, done, err;

  int n_checks = 0;
  int n_pass   = 0;
  int ready_mode = 0;
  logic [AW+31:0] obs_q[$];
  logic [31:0]    exp_q[$];
  logic [AW-1:0]  cur_base;

  instr_encoder #(.AW(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_funct(req_funct), .req_imm(req_imm), .req_target(req_target), .im_we(im_we),
    .im_ready(im_ready), .im_addr(im_addr), .im_wd(im_wd), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       im_ready = 1'b0;
      1:       im_ready = 1'b1;
      default: im_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Inputs only change just after a rising edge, so a write seen here commits next edge.
  always @(negedge clk) begin
    if (rst_n && im_we && im_ready) obs_q.push_back({im_addr, im_wd});
  end

  function automatic logic [31:0] ref_encode(input int kind, input logic [31:0] rs,
      input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] shamt,
      input logic [31:0] funct, input logic [31:0] imm, input logic [31:0] target);
    logic [31:0] op;
    op = 0;
    case (kind)
      0: return (rs << 21) | (rt << 16) | (rd << 11) | (shamt << 6) | funct;
      1: op = 32'h08;
      2: op = 32'h04;
      3: return (32'h02 << 26) | target;
      4: return (32'h03 << 26) | target;
      5: op = 32'h2B;
      6: op = 32'h23;
      default: return 32'h0;
    endcase
    return (op << 26) | (rs << 21) | (rt << 16) | imm;
  endfunction

  task automatic do_start(input logic [AW-1:0] base, input int len);
    base_addr = base;
    length    = (AW+1)'(len);
    start     = 1'b1;
    cur_base  = base;
    obs_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_req(input int kind, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
      input logic [15:0] imm, input logic [25:0] target, input int max_cyc, output bit ok);
    req_kind = 3'(kind); req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = shamt;
    req_funct = funct; req_imm = imm; req_target = target;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    req_valid = 1'b0;
    if (ok) begin
`ifdef INSTR_ENC_CHECK_EN
      if (kind != 7)
`endif
        exp_q.push_back(ref_encode(kind, 32'(rs), 32'(rt), 32'(rd), 32'(shamt),
                                   32'(funct), 32'(imm), 32'(target)));
    end
  endtask

  task automatic send_rand(input int kind, input int max_cyc, output bit ok);
    send_req(kind, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             6'($urandom), 16'($urandom), 26'($urandom), max_cyc, ok);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) $display("[TB] FAIL %s_done_timeout got done=%b required 1", name, done);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, im_we, busy, done, err} !== 5'b0 || im_addr !== '0 || im_wd !== '0)
      $display("[TB] FAIL reset_outputs got rdy=%b we=%b busy=%b done=%b err=%b addr=%h wd=%h required all 0",
               req_ready, im_we, busy, done, err, im_addr, im_wd);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({req_ready, im_we} !== 2'b00)
        $display("[TB] FAIL idle_no_ready got rdy=%b we=%b required 0 0", req_ready, im_we);
      else n_pass++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] lit [4];
    bit ok;
    lit = '{32'h00221820, 32'h20220005, 32'h8FA80004, 32'h08000010};
    ready_mode = 1;
    do_start(10'h010, 4);
    send_req(0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 20, ok);
    send_req(1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'd5, 26'h0, 20, ok);
    send_req(6, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'd4, 26'h0, 20, ok);
    send_req(3, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 20, ok);
    wait_done("directed");
    n_checks++;
    if (obs_q.size() !== 4) $display("[TB] FAIL directed_count got %0d required 4", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {10'(10'h010 + i), lit[i]})
        $display("[TB] FAIL directed_write%0d got %h required %h", i, obs_q[i], {10'(10'h010 + i), lit[i]});
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({done, req_ready} !== 2'b10)
      $display("[TB] FAIL directed_final got done=%b rdy=%b required 1 0", done, req_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    bit ok;
    ready_mode = 0;
    do_start(AW'($urandom), 1);
    send_rand($urandom_range(0, 6), 20, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (im_we !== 1'b1 || exp_q.size() != 1 || im_wd !== exp_q[0] || im_addr !== cur_base)
        $display("[TB] FAIL latency_hold%0d got we=%b addr=%h wd=%h required 1 %h %h",
                 i, im_we, im_addr, im_wd, cur_base, exp_q.size() > 0 ? exp_q[0] : 32'hx);
      else n_pass++;
    end
    @(posedge clk); #1;
    ready_mode = 1;
    wait_done("latency");
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {cur_base, exp_q[0]})
      $display("[TB] FAIL latency_write got n=%0d required 1 word %h", obs_q.size(), exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int n_ok;
    ready_mode = 0;
    do_start(AW'($urandom), 5);
    n_ok = 0;
    for (int i = 0; i < 5; i++) begin
      send_rand($urandom_range(0, 6), 4, ok);
      if (ok) n_ok++;
    end
    @(negedge clk);
    n_checks++;
    if (n_ok != DEPTH || req_ready !== 1'b0 || im_we !== 1'b1 || obs_q.size() != 0)
      $display("[TB] FAIL bp_accept got acc=%0d rdy=%b we=%b writes=%0d required %0d 0 1 0",
               n_ok, req_ready, im_we, obs_q.size(), DEPTH);
    else n_pass++;
    @(posedge clk); #1;
    ready_mode = 1;
    send_rand($urandom_range(0, 6), 20, ok);
    wait_done("bp");
    n_checks++;
    if (obs_q.size() != 5) $display("[TB] FAIL bp_count got %0d required 5", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {AW'(cur_base + AW'(i)), exp_q[i]})
        $display("[TB] FAIL bp_write%0d got %h required %h", i, obs_q[i], {AW'(cur_base + AW'(i)), exp_q[i]});
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    bit ok;
    ready_mode = 2;
    do_start(10'h3FF, 2);
    send_rand($urandom_range(0, 6), 40, ok);
    send_rand($urandom_range(0, 6), 40, ok);
    wait_done("wrap");
    n_checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2 || obs_q[0] !== {10'h3FF, exp_q[0]} ||
        obs_q[1] !== {10'h000, exp_q[1]})
      $display("[TB] FAIL wrap_writes got n=%0d a0=%h a1=%h required 2 3ff 000", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0][AW+31:32] : 10'hx, obs_q.size() > 1 ? obs_q[1][AW+31:32] : 10'hx);
    else n_pass++;
  endtask

  task automatic test_abort();
    bit ok;
    ready_mode = 0;
    do_start(AW'($urandom), 8);
    for (int i = 0; i < 3; i++) send_rand($urandom_range(0, 6), 20, ok);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    ready_mode = 1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, im_we, req_ready} !== 4'b0)
      $display("[TB] FAIL abort_state got busy=%b done=%b we=%b rdy=%b required 0 0 0 0",
               busy, done, im_we, req_ready);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0) $display("[TB] FAIL abort_no_write got %0d required 0", obs_q.size());
    else n_pass++;
    @(posedge clk); #1;
    do_start(10'h100, 2);
    send_rand($urandom_range(0, 6), 20, ok);
    send_rand($urandom_range(0, 6), 20, ok);
    wait_done("abort_restart");
    n_checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2 || obs_q[0] !== {10'h100, exp_q[0]} ||
        obs_q[1] !== {10'h101, exp_q[1]})
      $display("[TB] FAIL abort_restart got n=%0d first=%h required 2 words from 100", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : 42'hx);
    else n_pass++;
  endtask

  task automatic test_illegal();
    bit ok;
    ready_mode = 1;
    do_start(AW'($urandom), 3);
    send_rand(1, 20, ok);
    send_rand(7, 20, ok);
    repeat (3) @(negedge clk);
`ifdef INSTR_ENC_CHECK_EN
    n_checks++;
    if (err !== 1'b1 || obs_q.size() != 1)
      $display("[TB] FAIL illegal_dropped got err=%b writes=%0d required 1 1", err, obs_q.size());
    else n_pass++;
    @(posedge clk); #1;
    send_rand(6, 20, ok);
    send_rand(5, 20, ok);
`else
    n_checks++;
    if (err !== 1'b0 || obs_q.size() != 2 || obs_q[1][31:0] !== 32'h0)
      $display("[TB] FAIL illegal_nop got err=%b writes=%0d required 0 2 with NOP", err, obs_q.size());
    else n_pass++;
    @(posedge clk); #1;
    send_rand(6, 20, ok);
`endif
    wait_done("illegal");
    n_checks++;
    if (obs_q.size() != 3) $display("[TB] FAIL illegal_count got %0d required 3", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {AW'(cur_base + AW'(i)), exp_q[i]})
        $display("[TB] FAIL illegal_write%0d got %h required %h", i, obs_q[i], {AW'(cur_base + AW'(i)), exp_q[i]});
      else n_pass++;
    end
`ifdef INSTR_ENC_CHECK_EN
    do_start(AW'($urandom), 0);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) $display("[TB] FAIL start_clears_err got %b required 0", err);
    else n_pass++;
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_zero_length();
    do_start(AW'($urandom), 0);
    @(negedge clk);
    n_checks++;
    if ({done, busy, req_ready, im_we} !== 4'b1000)
      $display("[TB] FAIL zero_len got done=%b busy=%b rdy=%b we=%b required 1 0 0 0",
               done, busy, req_ready, im_we);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    ready_mode = 0;
    do_start(AW'($urandom), 4);
    send_rand($urandom_range(0, 6), 20, ok);
    send_rand($urandom_range(0, 6), 20, ok);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({im_we, busy, done} !== 3'b0 || im_addr !== '0)
      $display("[TB] FAIL reset_mid got we=%b busy=%b done=%b addr=%h required 0 0 0 0",
               im_we, busy, done, im_addr);
    else n_pass++;
    ready_mode = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || im_we !== 1'b0)
      $display("[TB] FAIL reset_mid_no_write got %0d writes we=%b required 0 0", obs_q.size(), im_we);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit ok;
    int len;
    for (int s = 0; s < 4; s++) begin
      ready_mode = 2;
      len = $urandom_range(1, 8);
      do_start(AW'($urandom), len);
      for (int i = 0; i < len; i++) begin
`ifdef INSTR_ENC_CHECK_EN
        send_rand($urandom_range(0, 6), 60, ok);
`else
        send_rand($urandom_range(0, 7), 60, ok);
`endif
      end
      wait_done("random");
      n_checks++;
      if (obs_q.size() != len) $display("[TB] FAIL random_count got %0d required %0d", obs_q.size(), len);
      else n_pass++;
      for (int i = 0; i < len && i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== {AW'(cur_base + AW'(i)), exp_q[i]})
          $display("[TB] FAIL random_write%0d got %h required %h", i, obs_q[i], {AW'(cur_base + AW'(i)), exp_q[i]});
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_backpressure();
    test_wrap();
    test_abort();
    test_illegal();
    test_zero_length();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Request-driven MIPS instruction encoder and instruction-memory loader. Accepts field-level requests for the supported instruction classes (R-type, ADDI, BEQ, J, JAL, SW, LW) and packs each one into a 32-bit instruction word. Buffers the words in a small FIFO and streams them into the instruction-memory write port at consecutive word addresses from a programmable base. Used by the test harness and boot path to load programs before the core leaves reset.

## Interface
- `AW`, 10, instruction-memory word-address width
- `FIFO_DEPTH`, 4, encoded-word buffer depth (power of 2, ≥2)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a load session
- `base_addr`  in  AW  first word address (sampled on `start`)
- `length`  in  AW+1  words in session (sampled on `start`); 0 means immediate done
- `abort`  in  1  cancel session, flush FIFO
- `req_valid`  in  1  request valid
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_kind`  in  3  0=R 1=ADDI 2=BEQ 3=J 4=JAL 5=SW 6=LW 7=illegal
- `req_rs`, `req_rt`, `req_rd`  in  5 each  register fields
- `req_shamt`  in  5  R-type shamt
- `req_funct`  in  6  R-type funct
- `req_imm`  in  16  I-type immediate
- `req_target`  in  26  J/JAL target
- `im_we`  out  1  write request to instruction memory
- `im_ready`  in  1  memory accepts write this cycle
- `im_addr`  out  AW  word address
- `im_wd`  out  32  instruction word
- `busy`  out  1  state is LOAD
- `done`  out  1  state is DONE
- `err`  out  1  sticky illegal-request flag (only with macro)

## Operation
- States: IDLE, LOAD, DONE.
  - IDLE→LOAD on `start` (`length`≠0).
  - IDLE→DONE on `start` with `length`=0.
  - LOAD→DONE when the write count reaches `length`.
  - DONE→LOAD/DONE on `start` (new session).
  - Any state→IDLE on `abort`. `abort` wins over `start` in the same cycle.
- Encoding:
  - R: {6'h00, rs, rt, rd, shamt, funct}
  - ADDI: {6'h08, rs, rt, imm}
  - BEQ: {6'h04, rs, rt, imm}
  - J: {6'h02, target}
  - JAL: {6'h03, target}
  - SW: {6'h2B, rs, rt, imm}
  - LW: {6'h23, rs, rt, imm}
  - Unused fields are ignored.
- `req_ready` = LOAD & FIFO not full & accepted count < `length`. An accepted request pushes its encoded word into the FIFO.
- `im_we` = LOAD & FIFO not empty. `im_addr`/`im_wd` come from the address counter and the FIFO head.
- On `im_we & im_ready`: pop the FIFO, increment `im_addr` (wraps modulo 2^AW), increment the write count.
- `start` clears the accepted and write counts, loads the address counter from `base_addr`, and empties the FIFO. It is ignored while in LOAD.
- `abort` empties the FIFO and zeroes both counts. `im_we` drops in the following cycle. `err` is held.
- Simultaneous push and pop on a full FIFO is allowed only through the pop side: the full check uses the current occupancy, so no push happens when full.

## Timing
- Reset values: state IDLE, `req_ready`=0, `im_we`=0, `im_addr`=0, `im_wd`=0, `busy`=0, `done`=0, `err`=0, FIFO empty, counts 0.
- Latency: request accepted at edge N → `im_we` high in cycle N+1 with the encoded word. Throughput is 1 word/cycle when `im_ready` is held high.
- `im_addr`/`im_wd` are stable while `im_we & !im_ready`.
- `done` rises in the cycle after the last write commits.
- `rst_n` low mid-session: immediate return to reset values. Nothing is written after reset is asserted.

## Configuration
- `INSTR_ENC_CHECK_EN` defined:
  - `req_kind`=7 is accepted (handshake completes) but not pushed and not counted.
  - `err` sets and stays set until reset or `start`.
- Macro undefined:
  - `req_kind`=7 encodes as 32'h00000000 (NOP) and is written like any other request.
  - `err` is tied 0.

## Test plan
- Reset then idle: all outputs at reset values; `req_valid`=1 with no `start` → `req_ready` stays 0, no `im_we`.
- `start` base=0x010, length=4, `im_ready`=1, requests:
  - R add rs=1 rt=2 rd=3 funct=0x20 → 0x00221820 @0x010
  - ADDI rs=1 rt=2 imm=5 → 0x20220005 @0x011
  - LW rs=29 rt=8 imm=4 → 0x8FA80004 @0x012
  - J target=0x10 → 0x08000010 @0x013
  - then `done`=1 and `req_ready`=0.
- Backpressure: `im_ready`=0 with 5 requests offered → exactly FIFO_DEPTH accepted, `req_ready` drops. Release `im_ready` → all words written in order, addresses contiguous.
- Wrap: base=2^AW−1, length=2 → writes at 0x3FF then 0x000.
- Abort with 3 words queued and `im_ready`=0 → next cycle state IDLE, `im_we`=0, no further writes; a new `start` works normally.
- Illegal kind=7 mid-stream: with macro → `err`=1 and write count unchanged; without macro → 0x00000000 written.
